nco_ctrl: RTL and testbench
===========================

Name: nco_ctrl

Overview:
Sequencing controller for the C/A-code NCO and code generator.
- Accepts frequency/code-phase configurations through a valid/ready handshake and programs the NCO frequency word with a one-cycle load strobe.
- Slews code phase by suppressing a programmed number of NCO chip ticks.
- Gates chip ticks to the code shift register as a chip enable, and tracks chip index and 1 ms code-epoch boundaries.
- Sits between the tracking-loop logic and the nco / shift_reg pair.

Parameters:
- FW, 9, NCO frequency-correction word width (bits).
- CODE_LEN, 1023, chips per code epoch.
- CW, 10, chip counter / slew width; must satisfy 2^CW >= CODE_LEN.
- DEFAULT_FREQ, 0, value driven on nco_freq after reset.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  controller can accept a configuration.
- cfg_freq  in  FW  new NCO frequency-correction word.
- cfg_slew  in  CW  number of chip ticks to suppress after loading.
- stop  in  1  halt request, level-sampled.
- chip_tick  in  1  one-cycle pulse from the NCO per chip.
- nco_freq  out  FW  registered frequency word to the NCO.
- nco_load  out  1  one-cycle strobe; the NCO samples nco_freq on it.
- chip_en  out  1  one-cycle shift enable to the code generator.
- chip_cnt  out  CW  index of the last enabled chip, range 0..CODE_LEN-1.
- epoch  out  1  one-cycle pulse with the chip_en that wraps chip_cnt to 0.
- busy  out  1  high in LOAD or SLEW.

Behaviour:
- Reset (synchronous): state=IDLE, nco_freq=DEFAULT_FREQ, nco_load=0, chip_en=0, chip_cnt=0, epoch=0, busy=0, running flag=0, slew_rem=0. cfg_ready=1 from the first cycle after reset.
- All outputs are registered except cfg_ready and busy, which decode state combinationally.
- cfg_ready=1 in IDLE and RUN; 0 in LOAD and SLEW.
- A handshake completes on cfg_valid & cfg_ready at a clk edge. On that edge: latch cfg_freq into nco_freq, latch cfg_slew into slew_rem, state->LOAD.
- stop has priority over everything except rst. In any state, stop=1 at an edge gives:
  - state->IDLE, running=0, chip_cnt=0, chip_en=0, epoch=0, nco_load=0.
  - nco_freq is held.
  - A simultaneous cfg_valid is ignored; no handshake completes.
- LOAD (exactly 1 cycle):
  - nco_load=1 during this cycle, with the new nco_freq already stable.
  - Next state: slew_rem!=0 -> SLEW, else RUN. Set running=1.
- SLEW:
  - Each chip_tick decrements slew_rem; chip_en stays 0 and chip_cnt is frozen.
  - The tick that takes slew_rem from 1 to 0 is also suppressed; state->RUN on that edge.
  - No ticks means SLEW is held indefinitely.
- RUN:
  - chip_tick at edge N -> chip_en=1 for the cycle after edge N (latency 1).
  - chip_cnt updates on the same edge: CODE_LEN-1 wraps to 0, otherwise +1.
  - epoch=1 in the same cycle as the chip_en whose update produced chip_cnt=0.
  - The first chip_en after start from IDLE gives chip_cnt=1. chip_cnt=0 is reached only on wrap.
- chip_tick during LOAD:
  - running=1 before this load (reconfig from RUN): treated as a RUN tick, no loss.
  - running=0 (start from IDLE): dropped.
- chip_tick in IDLE: ignored.
- Reconfiguration from RUN preserves chip_cnt; slew delays the code relative to the NCO.
- cfg_slew=0 gives no suppression. cfg_slew values >= CODE_LEN are legal and suppress that many ticks.
- Back-to-back cfg_valid: a second handshake cannot complete before the controller re-enters RUN (cfg_ready=0 in LOAD/SLEW).
- rst asserted mid-slew or mid-load: the reset values above apply on the next edge; no partial load strobe follows.

Optional Feature:
Macro NCO_CTRL_NAVBIT_EN.
- Defined:
  - Adds output navbit_cnt (5 bits, reset 0), incremented on each epoch and wrapping 19->0.
  - Adds output bit_edge (1 bit, reset 0), pulsing with the epoch that wraps navbit_cnt to 0 (20 ms nav-bit boundary).
  - stop clears navbit_cnt.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then cfg_valid with freq=9'h0A5, slew=0 -> cfg_ready high, nco_load single pulse with nco_freq=0A5 in the cycle after the handshake. 3 chip_ticks -> chip_en pulses each one cycle late, chip_cnt=1,2,3.
- slew=5 from IDLE, 8 chip_ticks -> busy high until the 5th tick, first chip_en on the 6th tick, chip_cnt reaches 3.
- 1023 ticks in RUN starting at chip_cnt=1021 -> chip_cnt 1022 then 0, epoch pulses exactly once, coincident with the chip_en giving 0.
- In RUN at chip_cnt=100, reconfig freq=9'h1FF, slew=2, with chip_tick in the LOAD cycle -> that tick counted (chip_cnt=101), next 2 ticks suppressed, following tick gives chip_cnt=102.
- stop asserted together with cfg_valid during SLEW -> next cycle IDLE, chip_cnt=0, no nco_load, cfg_ready=1. rst mid-SLEW -> all outputs at reset values.
- With NCO_CTRL_NAVBIT_EN: run 40 epochs -> bit_edge pulses at epochs 20 and 40, navbit_cnt wraps 19->0.

Source files
------------

// File: rtl/nco_ctrl_if.sv
// nco_ctrl_if: configuration handshake carrying frequency word and code-phase slew
interface nco_ctrl_if #(parameter int FW = 9, parameter int CW = 10);
    logic valid;
    logic ready;
    logic [FW-1:0] freq;
    logic [CW-1:0] slew;
    modport master(output valid, freq, slew, input ready);
    modport slave(input valid, freq, slew, output ready);
endinterface

// File: rtl/nco_ctrl.sv
// nco_ctrl: C/A-code NCO sequencer - loads frequency words, slews code phase, gates chip enables.
// Optional NCO_CTRL_NAVBIT_EN adds 20 ms nav-bit counting (navbit_cnt, bit_edge).
module nco_ctrl #(
    parameter int FW = 9,
    parameter int CODE_LEN = 1023,
    parameter int CW = 10,
    parameter logic [FW-1:0] DEFAULT_FREQ = '0
) (
    input  logic clk,
    input  logic rst,
    nco_ctrl_if.slave cfg,
    input  logic stop,
    input  logic chip_tick,
    output logic [FW-1:0] nco_freq,
    output logic nco_load,
    output logic chip_en,
    output logic [CW-1:0] chip_cnt,
    output logic epoch,
    output logic busy
`ifdef NCO_CTRL_NAVBIT_EN
    ,
    output logic [4:0] navbit_cnt,
    output logic bit_edge
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, SLEW, RUN} state_t;
    state_t state, state_nx;
    logic [CW-1:0] slew_rem;
    logic running, hs, adv, wrap, slew_step;
    assign cfg.ready = (state == IDLE) || (state == RUN);
    assign busy = (state == LOAD) || (state == SLEW);
    assign hs = cfg.valid && cfg.ready && !stop;
    // a tick in LOAD only counts when the code was already running before the reload
    assign adv = chip_tick && !stop && ((state == RUN) || (state == LOAD && running));
    assign wrap = chip_cnt == CW'(CODE_LEN - 1);
    assign slew_step = chip_tick && !stop && (state == SLEW);
    always_comb begin
        state_nx = state;
        state_nx = stop ? IDLE :
                   hs ? LOAD :
                   (state == LOAD) ? ((slew_rem != '0) ? SLEW : RUN) :
                   (slew_step && slew_rem == CW'(1)) ? RUN : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            nco_freq <= DEFAULT_FREQ;
            nco_load <= 1'b0;
            chip_en <= 1'b0;
            chip_cnt <= '0;
            epoch <= 1'b0;
            running <= 1'b0;
            slew_rem <= '0;
        end else begin
            state <= state_nx;
            nco_load <= hs;
            chip_en <= adv;
            epoch <= adv && wrap;
            if (adv) chip_cnt <= wrap ? '0 : chip_cnt + 1'b1;
            if (hs) begin
                nco_freq <= cfg.freq;
                slew_rem <= cfg.slew;
            end else if (slew_step) begin
                slew_rem <= slew_rem - 1'b1;
            end
            if (state == LOAD) running <= 1'b1;
            if (stop) begin
                running <= 1'b0;
                chip_cnt <= '0;
            end
        end
    end
`ifdef NCO_CTRL_NAVBIT_EN
    logic nb_wrap;
    assign nb_wrap = navbit_cnt == 5'd19;
    always_ff @(posedge clk) begin
        if (rst || stop) begin
            navbit_cnt <= '0;
            bit_edge <= 1'b0;
        end else begin
            bit_edge <= adv && wrap && nb_wrap;
            if (adv && wrap) navbit_cnt <= nb_wrap ? '0 : navbit_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_nco_ctrl.sv
// tb_nco_ctrl: directed stimulus against an abstract per-edge model plus literal spot checks.
module tb_nco_ctrl;
    localparam int FW = 9;
    localparam int CL = 1023;
    localparam int CW = 10;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stop = 1'b0;
    logic chip_tick = 1'b0;
    logic [FW-1:0] nco_freq;
    logic nco_load, chip_en, epoch, busy;
    logic [CW-1:0] chip_cnt;
`ifdef NCO_CTRL_NAVBIT_EN
    logic [4:0] navbit_cnt;
    logic bit_edge;
`endif
    always #5 clk = ~clk;
    nco_ctrl_if #(.FW(FW), .CW(CW)) cfg();
    nco_ctrl #(.FW(FW), .CODE_LEN(CL), .CW(CW), .DEFAULT_FREQ(9'h0)) dut (
        .clk(clk),
        .rst(rst),
        .cfg(cfg),
        .stop(stop),
        .chip_tick(chip_tick),
        .nco_freq(nco_freq),
        .nco_load(nco_load),
        .chip_en(chip_en),
        .chip_cnt(chip_cnt),
        .epoch(epoch),
        .busy(busy)
`ifdef NCO_CTRL_NAVBIT_EN
        ,
        .navbit_cnt(navbit_cnt),
        .bit_edge(bit_edge)
`endif
    );
    int tests = 0;
    int fails = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: mode 0 idle, 1 loading, 2 slewing, 3 running; pend = ticks still to swallow
    int m_mode, m_old, m_pend, m_cnt, m_nav;
    bit m_run, m_load, m_en, m_ep, m_edge, m_hs, m_count, armed = 1'b0;
    logic [FW-1:0] m_freq;
    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_pend = 0; m_cnt = 0; m_nav = 0; m_run = 0;
            m_load = 0; m_en = 0; m_ep = 0; m_edge = 0; m_freq = '0; armed = 1;
        end else if (stop) begin
            m_mode = 0; m_run = 0; m_cnt = 0; m_nav = 0;
            m_load = 0; m_en = 0; m_ep = 0; m_edge = 0;
        end else begin
            m_old = m_mode;
            m_hs = cfg.valid && (m_old == 0 || m_old == 3);
            m_count = chip_tick && (m_old == 3 || (m_old == 1 && m_run));
            m_en = m_count; m_ep = 0; m_edge = 0;
            if (m_count) begin
                m_cnt = (m_cnt + 1) % CL;
                if (m_cnt == 0) begin
                    m_ep = 1;
                    m_nav = (m_nav + 1) % 20;
                    m_edge = m_nav == 0;
                end
            end
            if (m_old == 2 && chip_tick) begin
                m_pend--;
                if (m_pend == 0) m_mode = 3;
            end
            if (m_old == 1) begin
                m_run = 1;
                m_mode = (m_pend > 0) ? 2 : 3;
            end
            m_load = m_hs;
            if (m_hs) begin
                m_freq = cfg.freq;
                m_pend = int'(cfg.slew);
                m_mode = 1;
            end
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            chk("nco_freq", 32'(nco_freq), 32'(m_freq));
            chk("nco_load", 32'(nco_load), 32'(m_load));
            chk("chip_en", 32'(chip_en), 32'(m_en));
            chk("chip_cnt", 32'(chip_cnt), 32'(m_cnt));
            chk("epoch", 32'(epoch), 32'(m_ep));
            chk("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
            chk("cfg_ready", 32'(cfg.ready), 32'(m_mode == 0 || m_mode == 3));
`ifdef NCO_CTRL_NAVBIT_EN
            chk("navbit_cnt", 32'(navbit_cnt), 32'(m_nav));
            chk("bit_edge", 32'(bit_edge), 32'(m_edge));
`endif
        end
    end
    task automatic cyc(bit v = 0, logic [FW-1:0] f = '0, logic [CW-1:0] s = '0, bit st = 0, bit t = 0);
        cfg.valid = v; cfg.freq = f; cfg.slew = s; stop = st; chip_tick = t;
        @(negedge clk);
    endtask
    task automatic ticks(int n);
        repeat (n) cyc(0, '0, '0, 0, 1);
    endtask
    initial begin
        int eps, edges;
        cfg.valid = 0; cfg.freq = '0; cfg.slew = '0;
        rst = 1;
        cyc(); cyc();
        rst = 0;
        chk("rst_ready", 32'(cfg.ready), 1);
        chk("rst_freq", 32'(nco_freq), 0);
        chk("rst_cnt", 32'(chip_cnt), 0);
        // start from IDLE, no slew
        cyc(1, 9'h0A5, 0);
        chk("t1_load", 32'(nco_load), 1);
        chk("t1_freq", 32'(nco_freq), 32'h0A5);
        cyc();
        chk("t1_load_end", 32'(nco_load), 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, '0, '0, 0, 1);
            chk("t1_en", 32'(chip_en), 1);
            chk("t1_cnt", 32'(chip_cnt), 32'(i));
            cyc();
            chk("t1_en_low", 32'(chip_en), 0);
        end
        // slew of 5 from IDLE
        cyc(0, '0, '0, 1);
        chk("t2_stop_cnt", 32'(chip_cnt), 0);
        cyc(1, '0, 5);
        cyc();
        for (int i = 1; i <= 8; i++) begin
            cyc(0, '0, '0, 0, 1);
            if (i == 4) chk("t2_busy4", 32'(busy), 1);
            if (i == 5) chk("t2_busy5", 32'(busy), 0);
            if (i == 5) chk("t2_en5", 32'(chip_en), 0);
            if (i == 6) chk("t2_en6", 32'(chip_en), 1);
        end
        chk("t2_cnt", 32'(chip_cnt), 3);
        // epoch wrap
        ticks(1018);
        chk("t3_cnt1021", 32'(chip_cnt), 1021);
        eps = 0;
        for (int i = 0; i < 1023; i++) begin
            cyc(0, '0, '0, 0, 1);
            if (i == 0) chk("t3_cnt1022", 32'(chip_cnt), 1022);
            if (epoch) begin
                eps++;
                chk("t3_epoch_cnt0", 32'(chip_cnt), 0);
            end
        end
        chk("t3_epoch_once", 32'(eps), 1);
        // reconfig from RUN with a tick in LOAD
        ticks(102);
        chk("t4_cnt100", 32'(chip_cnt), 100);
        cyc(1, 9'h1FF, 2);
        chk("t4_freq", 32'(nco_freq), 32'h1FF);
        cyc(0, '0, '0, 0, 1);
        chk("t4_cnt101", 32'(chip_cnt), 101);
        chk("t4_busy", 32'(busy), 1);
        ticks(2);
        chk("t4_slew_hold", 32'(chip_cnt), 101);
        chk("t4_busy_end", 32'(busy), 0);
        ticks(1);
        chk("t4_cnt102", 32'(chip_cnt), 102);
        // stop with cfg_valid during SLEW
        cyc(1, 9'h033, 3);
        cyc();
        cyc(0, '0, '0, 0, 1);
        cyc(1, 9'h044, 0, 1);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ready", 32'(cfg.ready), 1);
        chk("t5_cnt", 32'(chip_cnt), 0);
        chk("t5_load", 32'(nco_load), 0);
        chk("t5_freq_held", 32'(nco_freq), 32'h033);
        cyc(0, '0, '0, 0, 1);
        chk("t5_idle_tick", 32'(chip_en), 0);
        // tick during LOAD from IDLE is dropped, then reset mid-slew
        cyc(1, 9'h055, 4);
        cyc(0, '0, '0, 0, 1);
        chk("t5_drop_en", 32'(chip_en), 0);
        chk("t5_slew_busy", 32'(busy), 1);
        cyc(0, '0, '0, 0, 1);
        rst = 1;
        cyc();
        chk("t5_rst_freq", 32'(nco_freq), 0);
        chk("t5_rst_load", 32'(nco_load), 0);
        chk("t5_rst_en", 32'(chip_en), 0);
        chk("t5_rst_cnt", 32'(chip_cnt), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_ready", 32'(cfg.ready), 1);
        rst = 0;
        cyc();
        chk("t5_post_load", 32'(nco_load), 0);
`ifdef NCO_CTRL_NAVBIT_EN
        cyc(1, 9'h011, 0);
        cyc();
        eps = 0;
        edges = 0;
        for (int i = 0; i < 40 * CL; i++) begin
            cyc(0, '0, '0, 0, 1);
            if (epoch) eps++;
            if (bit_edge) begin
                edges++;
                chk("nav_edge_epoch", 32'(eps % 20), 0);
                chk("nav_wrap", 32'(navbit_cnt), 0);
            end
        end
        chk("nav_epochs", 32'(eps), 40);
        chk("nav_edges", 32'(edges), 2);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
